// File: rtl/rfid_rx_pkg.sv
// Shared types and constants for the reply-frame receive controller.
package rfid_rx_pkg;

    localparam int BANKS      = 9;
    localparam int BANK_WIDTH = $clog2(BANKS);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECEIVE,
        DONE
    } rx_state_e;

endpackage

// File: rtl/rx_watchdog.sv
// Loadable down-counter; expired flags the tick that would take it to zero,
// so the owner can react on the same edge the count runs out.
module rx_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && !load && (cnt_q <= W'(1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// Reply-frame receive controller: arms the preamble detector, waits for lock,
// then forwards a fixed number of payload bits under arm and gap watchdogs.
module rx_frame_ctrl
    import rfid_rx_pkg::*;
#(
    parameter int BANKS = rfid_rx_pkg::BANKS,
    parameter int LEN_W = 8,
    parameter int TMO_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [TMO_W-1:0]         cfg_arm_tmo,
    input  logic [TMO_W-1:0]         cfg_gap_tmo,
    output logic                     det_rst,
    input  logic                     det_dat,
    input  logic                     det_vld,
    input  logic                     preamble_detected,
    input  logic [$clog2(BANKS)-1:0] frequency_bank,
    output logic                     frame_dat,
    output logic                     frame_vld,
    output logic                     frame_last,
    output logic [$clog2(BANKS)-1:0] frame_bank,
    output logic                     busy,
    output logic                     done,
    output logic                     err_tmo,
    output logic                     err_gap,
    output logic                     err_cfg
);

    rx_state_e state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [TMO_W-1:0] gap_tmo_q, gap_tmo_d;

    logic                     det_rst_q, det_rst_d;
    logic                     frame_dat_q, frame_dat_d;
    logic                     frame_vld_q, frame_vld_d;
    logic                     frame_last_q, frame_last_d;
    logic [$clog2(BANKS)-1:0] frame_bank_q, frame_bank_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_tmo_q, err_tmo_d;
    logic                     err_gap_q, err_gap_d;
    logic                     err_cfg_q, err_cfg_d;

    logic arm_ok, lock, accept_bit;
    logic arm_tick, arm_expired;
    logic gap_load, gap_tick, gap_expired;

    // Abort masks every qualified event so nothing is latched or pulsed on that edge.
    assign arm_ok      = (state_q == IDLE) && arm && (cfg_len != '0) && !abort;
    assign lock        = (state_q == ARMED) && preamble_detected && !abort;
    assign accept_bit  = (state_q == RECEIVE) && det_vld && !frame_last_q && !abort;
    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    assign arm_tick = (state_q == ARMED);
    assign gap_load = lock || accept_bit;
    assign gap_tick = (state_q == RECEIVE) && !det_vld && !frame_last_q;

    // The arm timeout is only needed at load time, so the timer itself holds it.
    rx_watchdog #(.W(TMO_W)) u_arm_wdg (
        .clk      (clk),
        .rst      (rst),
        .load     (arm_ok),
        .load_val (cfg_arm_tmo),
        .tick     (arm_tick),
        .expired  (arm_expired)
    );

    rx_watchdog #(.W(TMO_W)) u_gap_wdg (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_tmo_q),
        .tick     (gap_tick),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RECEIVE lingers one cycle after the last bit so done trails frame_last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (arm_ok) state_d = ARMED;
            end
            ARMED: begin
                if (preamble_detected) state_d = RECEIVE;
                else if (arm_expired)  state_d = IDLE;
            end
            RECEIVE: begin
                if (frame_last_q)                  state_d = DONE;
                else if (!det_vld && gap_expired)  state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        len_d        = len_q;
        gap_tmo_d    = gap_tmo_q;
        bit_cnt_d    = bit_cnt_q;
        frame_bank_d = frame_bank_q;
        frame_vld_d  = 1'b0;
        frame_dat_d  = 1'b0;
        frame_last_d = 1'b0;

        if (arm_ok) begin
            len_d     = cfg_len;
            gap_tmo_d = cfg_gap_tmo;
        end
        if (lock) begin
            bit_cnt_d    = '0;
            frame_bank_d = frequency_bank;
        end
        if (accept_bit) begin
            bit_cnt_d    = bit_cnt_inc;
            frame_vld_d  = 1'b1;
            frame_dat_d  = det_dat;
            frame_last_d = (bit_cnt_inc == len_q);
        end

        done_d    = (state_d == DONE);
        err_tmo_d = (state_q == ARMED) && !preamble_detected && arm_expired && !abort;
        err_gap_d = (state_q == RECEIVE) && !frame_last_q && !det_vld && gap_expired && !abort;
        err_cfg_d = (state_q == IDLE) && arm && (cfg_len == '0) && !abort;
        busy_d    = (state_d != IDLE);
        det_rst_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            gap_tmo_q    <= '0;
            bit_cnt_q    <= '0;
            det_rst_q    <= 1'b1;
            frame_dat_q  <= 1'b0;
            frame_vld_q  <= 1'b0;
            frame_last_q <= 1'b0;
            frame_bank_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_gap_q    <= 1'b0;
            err_cfg_q    <= 1'b0;
        end else begin
            len_q        <= len_d;
            gap_tmo_q    <= gap_tmo_d;
            bit_cnt_q    <= bit_cnt_d;
            det_rst_q    <= det_rst_d;
            frame_dat_q  <= frame_dat_d;
            frame_vld_q  <= frame_vld_d;
            frame_last_q <= frame_last_d;
            frame_bank_q <= frame_bank_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_tmo_q    <= err_tmo_d;
            err_gap_q    <= err_gap_d;
            err_cfg_q    <= err_cfg_d;
        end
    end

    assign det_rst    = det_rst_q;
    assign frame_dat  = frame_dat_q;
    assign frame_vld  = frame_vld_q;
    assign frame_last = frame_last_q;
    assign frame_bank = frame_bank_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_tmo    = err_tmo_q;
    assign err_gap    = err_gap_q;
    assign err_cfg    = err_cfg_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: directed scenarios push cycle-stamped
// expected events; a negedge monitor pops and compares every output event.
module tb_rx_frame_ctrl;

    localparam int BANKS = 9;
    localparam int LEN_W = 8;
    localparam int TMO_W = 16;
    localparam int BW    = $clog2(BANKS);

    typedef struct packed {
        int unsigned   cyc;
        logic          vld;
        logic          dat;
        logic          last;
        logic [BW-1:0] bank;
        logic          done;
        logic          tmo;
        logic          gap;
        logic          cfg;
    } evT;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm, abort, detDat, detVld, preamble;
    logic [LEN_W-1:0] cfgLen;
    logic [TMO_W-1:0] cfgArmTmo, cfgGapTmo;
    logic [BW-1:0]    freqBank;
    logic             detRst, frameDat, frameVld, frameLast, busy, done;
    logic             errTmo, errGap, errCfg;
    logic [BW-1:0]    frameBank;

    int unsigned   cyc = 0;
    int            nCmp = 0;
    int            nFail = 0;
    evT            expQ[$];
    logic [BW-1:0] expBank = '0;

    rx_frame_ctrl #(.BANKS(BANKS), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .arm               (arm),
        .abort             (abort),
        .cfg_len           (cfgLen),
        .cfg_arm_tmo       (cfgArmTmo),
        .cfg_gap_tmo       (cfgGapTmo),
        .det_rst           (detRst),
        .det_dat           (detDat),
        .det_vld           (detVld),
        .preamble_detected (preamble),
        .frequency_bank    (freqBank),
        .frame_dat         (frameDat),
        .frame_vld         (frameVld),
        .frame_last        (frameLast),
        .frame_bank        (frameBank),
        .busy              (busy),
        .done              (done),
        .err_tmo           (errTmo),
        .err_gap           (errGap),
        .err_cfg           (errCfg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: flags overdue expectations, then matches any presented event.
    always @(negedge clk) begin
        evT got, want;
        if (!rst) begin
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                want = expQ.pop_front();
                nCmp++;
                nFail++;
                $display("[TB] FAIL missing event: due cyc=%0d vld=%b last=%b done=%b tmo=%b gap=%b cfg=%b, still outstanding at cyc=%0d",
                         want.cyc, want.vld, want.last, want.done, want.tmo, want.gap, want.cfg, cyc);
            end
            if (frameVld || frameLast || done || errTmo || errGap || errCfg) begin
                got = '{cyc: cyc, vld: frameVld, dat: frameVld ? frameDat : 1'b0, last: frameLast,
                        bank: frameBank, done: done, tmo: errTmo, gap: errGap, cfg: errCfg};
                nCmp++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL unexpected event @cyc=%0d: vld=%b dat=%b last=%b bank=%0d done=%b tmo=%b gap=%b cfg=%b",
                             cyc, got.vld, got.dat, got.last, got.bank, got.done, got.tmo, got.gap, got.cfg);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) begin
                        nFail++;
                        $display("[TB] FAIL event: got cyc=%0d vld=%b dat=%b last=%b bank=%0d done=%b tmo=%b gap=%b cfg=%b, want cyc=%0d vld=%b dat=%b last=%b bank=%0d done=%b tmo=%b gap=%b cfg=%b",
                                 got.cyc, got.vld, got.dat, got.last, got.bank, got.done, got.tmo, got.gap, got.cfg,
                                 want.cyc, want.vld, want.dat, want.last, want.bank, want.done, want.tmo, want.gap, want.cfg);
                    end
                end
            end
        end
    end

    // Drives one cycle of inputs; on return cyc is the edge that sampled them.
    task automatic applyStimulus(input logic a, input logic ab, input logic pd,
                                 input logic [BW-1:0] fb, input logic dv, input logic dd);
        arm = a; abort = ab; preamble = pd; freqBank = fb; detVld = dv; detDat = dd;
        @(posedge clk);
        #1;
        arm = 1'b0; abort = 1'b0; preamble = 1'b0; freqBank = '0; detVld = 1'b0; detDat = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCmp++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic pushBit(input int unsigned c, input logic d, input logic l);
        evT e;
        e = '0;
        e.cyc = c; e.vld = 1'b1; e.dat = d; e.last = l; e.bank = expBank;
        expQ.push_back(e);
    endtask

    task automatic pushStatus(input int unsigned c, input logic dn, input logic tm,
                              input logic gp, input logic cf);
        evT e;
        e = '0;
        e.cyc = c; e.bank = expBank; e.done = dn; e.tmo = tm; e.gap = gp; e.cfg = cf;
        expQ.push_back(e);
    endtask

    task automatic armWith(input int len, input int armTmo, input int gapTmo);
        cfgLen = LEN_W'(len); cfgArmTmo = TMO_W'(armTmo); cfgGapTmo = TMO_W'(gapTmo);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic lockOn(input logic [BW-1:0] fb);
        applyStimulus(1'b0, 1'b0, 1'b1, fb, 1'b0, 1'b0);
        expBank = fb;
    endtask

    task automatic sendBit(input logic d, input logic l);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, d);
        pushBit(cyc, d, l);
    endtask

    initial begin
        logic [4:0] patA;
        int unsigned s;
        logic d;

        rst = 1'b1;
        arm = 1'b0; abort = 1'b0; preamble = 1'b0; freqBank = '0; detVld = 1'b0; detDat = 1'b0;
        cfgLen = '0; cfgArmTmo = '0; cfgGapTmo = '0;
        idleCycles(3);
        checkOutput("reset det_rst", detRst, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_vld", frameVld, 0);
        checkOutput("reset frame_bank", frameBank, 0);
        checkOutput("reset status", {done, errTmo, errGap, errCfg, frameLast}, 0);
        rst = 1'b0;
        idleCycles(2);

        // Full 5-bit frame: lock at cycle 50 on bank 6, stray inputs ignored.
        armWith(5, 300, 20);
        s = cyc;
        checkOutput("armed busy", busy, 1);
        checkOutput("armed det_rst", detRst, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        cfgLen = 8'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cfgLen = 8'd5;
        idleCycles(int'(s + 49 - cyc));
        lockOn(4'd6);
        checkOutput("lock frame_bank", frameBank, 6);
        patA = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) idleCycles(2);
            applyStimulus(1'b0, 1'b0, (i == 2), 4'd2, 1'b1, patA[4-i]);
            pushBit(cyc, patA[4-i], (i == 4));
        end
        pushStatus(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("done-state busy", busy, 1);
        idleCycles(1);
        checkOutput("after done busy", busy, 0);
        checkOutput("after done det_rst", detRst, 1);

        // Arm timeout with no preamble.
        armWith(3, 10, 20);
        pushStatus(cyc + 10, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(10);
        checkOutput("tmo det_rst", detRst, 1);
        checkOutput("tmo busy", busy, 0);

        // Zero length rejected.
        armWith(0, 10, 20);
        pushStatus(cyc, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("cfg busy", busy, 0);
        idleCycles(1);

        // Preamble on the expiry cycle wins.
        armWith(2, 10, 20);
        idleCycles(9);
        lockOn(4'd3);
        checkOutput("race busy", busy, 1);
        checkOutput("race frame_bank", frameBank, 3);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b1);
        pushStatus(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        // Gap timeout; a bit on the expiry cycle still counts.
        armWith(5, 100, 4);
        lockOn(4'd1);
        sendBit(1'b1, 1'b0);
        idleCycles(3);
        sendBit(1'b1, 1'b0);
        pushStatus(cyc + 4, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(4);
        checkOutput("gap busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idleCycles(1);

        // Abort alongside bit 4, then abort masking a bad arm.
        armWith(5, 100, 20);
        lockOn(4'd5);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort det_rst", detRst, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        cfgLen = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idleCycles(2);

        // Reset after bit 3 drops the frame.
        armWith(5, 100, 20);
        lockOn(4'd7);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        idleCycles(1);
        rst = 1'b1;
        #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst det_rst", detRst, 1);
        checkOutput("rst frame_bank", frameBank, 0);
        expBank = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        idleCycles(2);

        // 64-bit frame with irregular gaps below the gap timeout.
        armWith(64, 100, 8);
        lockOn(4'd4);
        for (int i = 0; i < 64; i++) begin
            idleCycles($urandom_range(0, 6));
            d = 1'($urandom_range(0, 1));
            sendBit(d, (i == 63));
        end
        pushStatus(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(4);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter BANKS, default 9, number of frequency banks in the preamble detector.
REQ-002 SHALL have parameter LEN_W, default 8, width of the frame-length field.
REQ-003 SHALL have parameter TMO_W, default 16, width of the timeout fields.
REQ-004 SHALL have port clk  in  1  single clock; one clock domain, no others.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port arm  in  1  one-cycle request to start listening for a reply.
REQ-007 SHALL have port abort  in  1  unconditional return to IDLE.
REQ-008 SHALL have port cfg_len  in  LEN_W  expected payload bits after the preamble.
REQ-009 SHALL have port cfg_arm_tmo  in  TMO_W  cycles to wait for a preamble.
REQ-010 SHALL have port cfg_gap_tmo  in  TMO_W  maximum cycles between payload bits.
REQ-011 SHALL have port det_rst  out  1  holds the preamble detector cleared.
REQ-012 SHALL have port det_dat  in  1  detector output bit.
REQ-013 SHALL have port det_vld  in  1  detector output strobe.
REQ-014 SHALL have port preamble_detected  in  1  detector lock pulse.
REQ-015 SHALL have port frequency_bank  in  $clog2(BANKS)  bank index from the detector.
REQ-016 SHALL have ports frame_dat / frame_vld / frame_last  out  1 each  payload bit stream.
REQ-017 SHALL have port frame_bank  out  $clog2(BANKS)  bank latched at lock.
REQ-018 SHALL have ports busy, done, err_tmo, err_gap, err_cfg  out  1 each  status outputs (all pulses except busy).

Function
REQ-019 SHALL implement states IDLE, ARMED, RECEIVE and DONE.
REQ-020 IDLE SHALL drive det_rst=1 and busy=0; in every other state det_rst=0 and busy=1.
REQ-021 On arm in IDLE, cfg_len, cfg_arm_tmo and cfg_gap_tmo SHALL be latched and the next state SHALL be ARMED.
REQ-022 On arm with cfg_len==0, the block SHALL stay in IDLE and pulse err_cfg for 1 cycle.
REQ-023 arm outside IDLE SHALL be ignored.
REQ-024 ARMED SHALL decrement the arm timer every cycle, starting from the latched cfg_arm_tmo.
REQ-025 When the arm timer reaches 0 in ARMED, the block SHALL pulse err_tmo and go to IDLE.
REQ-026 On preamble_detected in ARMED, the block SHALL latch frequency_bank into frame_bank, clear the bit counter and go to RECEIVE.
REQ-027 If preamble_detected and arm-timer expiry occur in the same cycle, preamble_detected SHALL win.
REQ-028 In RECEIVE, every det_vld SHALL produce frame_vld exactly 1 cycle later, with frame_dat=det_dat.
REQ-029 The bit counter SHALL increment on each det_vld; frame_last SHALL assert together with the frame_vld of bit number cfg_len.
REQ-030 After the last bit, the state SHALL be DONE for exactly 1 cycle with done=1, then IDLE.
REQ-031 The gap timer SHALL reload to cfg_gap_tmo on entry to RECEIVE and on each det_vld.
REQ-032 When the gap timer reaches 0 without det_vld, the block SHALL pulse err_gap and go to IDLE; no frame_last is issued.
REQ-033 det_vld and gap-timer expiry in the same cycle SHALL count the bit and SHALL NOT raise err_gap.
REQ-034 det_vld outside RECEIVE SHALL be ignored: no frame_vld.
REQ-035 abort SHALL force IDLE on the next edge from any state, with no status pulse; abort overrides all simultaneous events.
REQ-036 preamble_detected in RECEIVE SHALL be ignored and frame_bank SHALL stay unchanged.
REQ-037 Every output SHALL be registered.

Reset
REQ-038 rst SHALL asynchronously set the state to IDLE, det_rst=1, and all other outputs, counters and timers to 0.
REQ-039 rst asserted mid-frame SHALL drop the frame with no frame_last, done or error pulse.

Structure
REQ-040 Package rfid_rx_pkg SHALL hold the state enum, BANKS and BANK_WIDTH=$clog2(BANKS).
REQ-041 The arm and gap timers SHALL each be an instance of one sub-module, rx_watchdog (load, tick, expired).

Verification
REQ-042 arm with cfg_len=5, arm_tmo=300, gap_tmo=20, preamble at cycle 50, bank=6, then 5 bits 10110 -> frame_bank=6, five frame_vld with 10110, frame_last on the 5th, done 1 cycle after it.
REQ-043 arm with arm_tmo=10, no preamble -> err_tmo pulse 10 cycles after arm and det_rst=1 afterwards.
REQ-044 RECEIVE with gap_tmo=4, 2 of 5 bits then silence -> err_gap after 4 idle cycles, no frame_last.
REQ-045 arm with cfg_len=0 -> err_cfg pulse, state stays IDLE; also preamble_detected on the cycle the timer hits 0 -> RECEIVE, no err_tmo.
REQ-046 abort or rst asserted after bit 3 of 5 -> IDLE next cycle, no done or error pulse, and later det_vld produces no frame_vld.
REQ-047 Random det_vld gaps (below gap_tmo) with cfg_len=64 -> exactly 64 frame_vld in order, then done.
